fabric_config_sequencer: RTL and testbench

- Wishbone slave that streams a configuration bitstream into the column shift chains of the CLB fabric.
- Software writes a column mask and a chain length, pushes 32-bit words into a small FIFO, then commits.
- The block serialises the bits LSB-first onto the selected columns, then issues a one-cycle set pulse so the tiles latch the new configuration.
- It sits between the Caravel Wishbone bus and the per-column cen/shift/set inputs at row 0 of the fabric.

---
 rtl/fabric_cfg_pkg.sv | 28 ++
 rtl/cfg_word_fifo.sv | 57 +++++
 rtl/fabric_config_sequencer.sv | 233 +++++++++++++++++++++++
 tb/tb_fabric_config_sequencer.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fabric_cfg_pkg.sv
// Shared definitions for the fabric configuration sequencer: register map,
// CTRL/STATUS bit positions and the sequencer state encoding.
package fabric_cfg_pkg;

    localparam logic [3:0] OFF_CTRL   = 4'h0;
    localparam logic [3:0] OFF_DATA   = 4'h4;
    localparam logic [3:0] OFF_LEN    = 4'h8;
    localparam logic [3:0] OFF_STATUS = 4'hC;

    localparam int CTRL_ABORT  = 30;
    localparam int CTRL_COMMIT = 31;

    localparam int ST_BUSY    = 0;
    localparam int ST_OVF     = 1;
    localparam int ST_EMPTY   = 2;
    localparam int ST_FULL    = 3;
    localparam int ST_LVL_LO  = 8;
    localparam int ST_DONE_LO = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_WAIT,
        S_SET
    } seq_state_t;

endpackage

// File: rtl/cfg_word_fifo.sv
// Synchronous word FIFO feeding the configuration shifter.
// Pushes into a full FIFO are dropped; flush empties it in one cycle.
module cfg_word_fifo #(
    parameter int DEPTH = 4,
    parameter int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [31:0]      i_data,
    input  logic             i_pop,
    output logic [31:0]      o_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [LVL_W-1:0] o_level
);

    localparam int AW = $clog2(DEPTH);

    logic [31:0]      r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [LVL_W-1:0] r_level;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_level == LVL_W'(DEPTH));
    assign o_empty   = (r_level == '0);
    assign o_level   = r_level;
    assign o_data    = r_mem[r_rptr];
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            r_level <= r_level + LVL_W'(w_do_push) - LVL_W'(w_do_pop);
        end
    end

endmodule

// File: rtl/fabric_config_sequencer.sv
// Wishbone slave that serialises FIFO'd 32-bit words LSB-first onto the
// masked fabric column shift chains, then pulses cfg_set once.
module fabric_config_sequencer
    import fabric_cfg_pkg::*;
#(
    parameter int          MX         = 6,
    parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
    parameter int          FIFO_DEPTH = 4,
    parameter int          LEN_W      = 16
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic          wbs_stb_i,
    input  logic          wbs_cyc_i,
    input  logic          wbs_we_i,
    input  logic [3:0]    wbs_sel_i,
    input  logic [31:0]   wbs_data_i,
    input  logic [31:0]   wbs_addr_i,
    output logic          wbs_ack_o,
    output logic [31:0]   wbs_data_o,
    output logic [MX-1:0] cfg_cen,
    output logic [MX-1:0] cfg_shift,
    output logic [MX-1:0] cfg_data,
    output logic [MX-1:0] cfg_set,
    output logic          busy
);

    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    seq_state_t       r_state;
    seq_state_t       w_state_nxt;

    logic             r_ack;
    logic             r_req_we;
    logic             r_req_sel_ok;
    logic [3:0]       r_req_off;
    logic [31:0]      r_req_data;

    logic [MX-1:0]    r_mask;
    logic [LEN_W-1:0] r_len;
    logic             r_ovf;
    logic [31:0]      r_sr;
    logic [4:0]       r_bitcnt;
    logic [LEN_W-1:0] r_bits_done;

    logic             w_hit;
    logic             w_wr;
    logic             w_rd;
    logic             w_wr_ctrl;
    logic             w_abort;
    logic             w_commit;
    logic             w_push;
    logic             w_pop;
    logic             w_shift_en;
    logic             w_busy;
    logic [LEN_W-1:0] w_done_nxt;
    logic [31:0]      w_fifo_data;
    logic             w_full;
    logic             w_empty;
    logic [LVL_W-1:0] w_level;
    logic             w_unused;

    assign w_hit = wbs_stb_i & wbs_cyc_i & (wbs_addr_i[31:4] == BASE_ADDR[31:4]);
    assign w_unused = &{1'b0, wbs_addr_i[1:0]};

    // The request is latched on the hit and takes effect at the end of the ack cycle.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_ack        <= 1'b0;
            r_req_we     <= 1'b0;
            r_req_sel_ok <= 1'b0;
            r_req_off    <= '0;
            r_req_data   <= '0;
        end else begin
            r_ack <= w_hit & ~r_ack;
            if (w_hit && !r_ack) begin
                r_req_we     <= wbs_we_i;
                r_req_sel_ok <= &wbs_sel_i;
                r_req_off    <= {wbs_addr_i[3:2], 2'b00};
                r_req_data   <= wbs_data_i;
            end
        end
    end

    assign wbs_ack_o  = r_ack;
    assign w_busy     = (r_state != S_IDLE);
    assign busy       = w_busy;
    assign w_wr       = r_ack & r_req_we & r_req_sel_ok;
    assign w_rd       = r_ack & ~r_req_we;
    assign w_wr_ctrl  = w_wr & (r_req_off == OFF_CTRL);
    assign w_abort    = w_wr_ctrl & r_req_data[CTRL_ABORT];
    assign w_commit   = w_wr_ctrl & r_req_data[CTRL_COMMIT] & ~w_abort & ~w_busy;
    assign w_push     = w_wr & (r_req_off == OFF_DATA);
    assign w_done_nxt = r_bits_done + LEN_W'(1);

    always_comb begin
        wbs_data_o = '0;
        if (w_rd) begin
            case (r_req_off)
                OFF_LEN: wbs_data_o[LEN_W-1:0] = r_len;
                OFF_STATUS: begin
                    wbs_data_o[ST_BUSY]            = w_busy;
                    wbs_data_o[ST_OVF]             = r_ovf;
                    wbs_data_o[ST_EMPTY]           = w_empty;
                    wbs_data_o[ST_FULL]            = w_full;
                    wbs_data_o[ST_LVL_LO +: 8]     = 8'(w_level);
                    wbs_data_o[ST_DONE_LO +: 16]   = 16'(r_bits_done);
                end
                default: wbs_data_o = '0;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_mask <= '0;
            r_len  <= '0;
            r_ovf  <= 1'b0;
        end else begin
            if (w_wr_ctrl && !w_abort && !w_busy) begin
                r_mask <= r_req_data[MX-1:0];
            end
            if (w_wr && (r_req_off == OFF_LEN) && !w_busy) begin
                r_len <= r_req_data[LEN_W-1:0];
            end
            if (w_push && w_full) begin
                r_ovf <= 1'b1;
            end else if (w_rd && (r_req_off == OFF_STATUS)) begin
                r_ovf <= 1'b0;
            end
        end
    end

    cfg_word_fifo #(
        .DEPTH (FIFO_DEPTH),
        .LVL_W (LVL_W)
    ) u_fifo (
        .i_clk   (wb_clk_i),
        .i_rst   (wb_rst_i),
        .i_flush (w_abort),
        .i_push  (w_push),
        .i_data  (r_req_data),
        .i_pop   (w_pop),
        .o_data  (w_fifo_data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (w_level)
    );

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_shift_en  = 1'b0;
        cfg_cen     = '0;
        cfg_shift   = '0;
        cfg_data    = '0;
        cfg_set     = '0;
        case (r_state)
            S_IDLE: begin
                if (w_commit) begin
                    w_state_nxt = (r_len != '0) ? S_LOAD : S_SET;
                end
            end
            S_LOAD: begin
                cfg_cen = r_mask;
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_SHIFT;
                end else begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_SHIFT: begin
                cfg_cen    = r_mask;
                cfg_shift  = r_mask;
                cfg_data   = r_mask & {MX{r_sr[0]}};
                w_shift_en = 1'b1;
                // Reaching LEN mid-word discards the rest of that word.
                if (w_done_nxt == r_len) begin
                    w_state_nxt = S_SET;
                end else if (r_bitcnt == 5'd31) begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_WAIT: begin
                cfg_cen = r_mask;
                if (!w_empty) begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_SET: begin
                cfg_cen     = r_mask;
                cfg_set     = r_mask;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_abort) begin
            w_state_nxt = S_IDLE;
            w_pop       = 1'b0;
            w_shift_en  = 1'b0;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_sr        <= '0;
            r_bitcnt    <= '0;
            r_bits_done <= '0;
        end else begin
            if (w_commit) begin
                r_bits_done <= '0;
            end
            if (w_pop) begin
                r_sr     <= w_fifo_data;
                r_bitcnt <= '0;
            end else if (w_shift_en) begin
                r_sr        <= {1'b0, r_sr[31:1]};
                r_bitcnt    <= r_bitcnt + 5'd1;
                r_bits_done <= w_done_nxt;
            end
        end
    end

endmodule

// File: tb/tb_fabric_config_sequencer.sv
// Directed bench for fabric_config_sequencer: register access, shifting,
// FIFO underflow/overflow, abort, zero-length commit and address decode.
module tb_fabric_config_sequencer;

    localparam logic [31:0] BASE     = 32'h3000_0000;
    localparam logic [31:0] A_CTRL   = BASE + 32'h0;
    localparam logic [31:0] A_DATA   = BASE + 32'h4;
    localparam logic [31:0] A_LEN    = BASE + 32'h8;
    localparam logic [31:0] A_STATUS = BASE + 32'hC;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i = 1'b1;
    logic        wbs_stb_i = 1'b0;
    logic        wbs_cyc_i = 1'b0;
    logic        wbs_we_i = 1'b0;
    logic [3:0]  wbs_sel_i = 4'h0;
    logic [31:0] wbs_data_i = '0;
    logic [31:0] wbs_addr_i = '0;
    logic        wbs_ack_o;
    logic [31:0] wbs_data_o;
    logic [5:0]  cfg_cen;
    logic [5:0]  cfg_shift;
    logic [5:0]  cfg_data;
    logic [5:0]  cfg_set;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;

    fabric_config_sequencer #(
        .MX         (6),
        .BASE_ADDR  (BASE),
        .FIFO_DEPTH (4),
        .LEN_W      (16)
    ) dut (
        .wb_clk_i   (wb_clk_i),
        .wb_rst_i   (wb_rst_i),
        .wbs_stb_i  (wbs_stb_i),
        .wbs_cyc_i  (wbs_cyc_i),
        .wbs_we_i   (wbs_we_i),
        .wbs_sel_i  (wbs_sel_i),
        .wbs_data_i (wbs_data_i),
        .wbs_addr_i (wbs_addr_i),
        .wbs_ack_o  (wbs_ack_o),
        .wbs_data_o (wbs_data_o),
        .cfg_cen    (cfg_cen),
        .cfg_shift  (cfg_shift),
        .cfg_data   (cfg_data),
        .cfg_set    (cfg_set),
        .busy       (busy)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] sel);
        logic got;
        got = 1'b0;
        wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = 1'b1;
        wbs_addr_i = a; wbs_data_i = d; wbs_sel_i = sel;
        for (int i = 0; i < 4 && !got; i++) begin
            tick();
            if (wbs_ack_o === 1'b1) got = 1'b1;
        end
        wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
        chk("wr_ack", {31'b0, got}, 32'd1);
    endtask

    task automatic wb_read(input logic [31:0] a, output logic [31:0] d);
        logic got;
        got = 1'b0;
        d = '0;
        wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = 1'b0;
        wbs_addr_i = a; wbs_sel_i = 4'hF;
        for (int i = 0; i < 4 && !got; i++) begin
            tick();
            if (wbs_ack_o === 1'b1) begin
                got = 1'b1;
                d = wbs_data_o;
            end
        end
        wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0;
        chk("rd_ack", {31'b0, got}, 32'd1);
    endtask

    task automatic chk_rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        wb_read(a, d);
        chk(tag, d, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w;
        logic [31:0] st;

        // Reset
        repeat (3) tick();
        chk("rst_cen", cfg_cen, 0);
        chk("rst_shift", cfg_shift, 0);
        chk("rst_data", cfg_data, 0);
        chk("rst_set", cfg_set, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ack", wbs_ack_o, 0);
        wb_rst_i = 1'b0;
        tick();
        chk_rd("rst_status", A_STATUS, 32'h0000_0004);
        chk_rd("rst_len", A_LEN, 32'h0);

        // Basic load: mask 000101, LEN 8, word A5
        wb_write(A_LEN, 32'd8, 4'hF);
        wb_write(A_DATA, 32'h0000_00A5, 4'hF);
        wb_write(A_CTRL, 32'h8000_0005, 4'hF);
        chk("b_busy_ack", busy, 0);
        tick();
        chk("b_load_busy", busy, 1);
        chk("b_load_cen", cfg_cen, 6'b000101);
        chk("b_load_shift", cfg_shift, 0);
        w = 32'h0000_00A5;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("b_shift", cfg_shift, 6'b000101);
            chk("b_data", cfg_data, w[i] ? 6'b000101 : 6'b0);
        end
        tick();
        chk("b_set", cfg_set, 6'b000101);
        chk("b_set_shift", cfg_shift, 0);
        tick();
        chk("b_idle_set", cfg_set, 0);
        chk("b_idle_busy", busy, 0);
        chk("b_idle_cen", cfg_cen, 0);
        chk_rd("b_status", A_STATUS, 32'h0008_0004);

        // Multi-word with underflow: LEN 40, mask 110010
        wb_write(A_LEN, 32'd40, 4'hF);
        wb_write(A_DATA, 32'h1234_5678, 4'hF);
        wb_write(A_CTRL, 32'h8000_0032, 4'hF);
        tick();
        chk("m_load_cen", cfg_cen, 6'b110010);
        w = 32'h1234_5678;
        for (int i = 0; i < 32; i++) begin
            tick();
            chk("m_shift1", cfg_shift, 6'b110010);
            chk("m_data1", cfg_data, w[i] ? 6'b110010 : 6'b0);
        end
        tick();
        chk("m_load2_shift", cfg_shift, 0);
        tick();
        chk("m_wait_shift", cfg_shift, 0);
        chk("m_wait_cen", cfg_cen, 6'b110010);
        tick();
        chk("m_wait2_shift", cfg_shift, 0);
        chk("m_wait2_busy", busy, 1);
        wb_write(A_DATA, 32'h0000_00C3, 4'hF);
        chk("m_ack_shift", cfg_shift, 0);
        tick();
        chk("m_wait3_shift", cfg_shift, 0);
        tick();
        chk("m_load3_shift", cfg_shift, 0);
        chk("m_load3_cen", cfg_cen, 6'b110010);
        w = 32'h0000_00C3;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("m_shift2", cfg_shift, 6'b110010);
            chk("m_data2", cfg_data, w[i] ? 6'b110010 : 6'b0);
        end
        tick();
        chk("m_set", cfg_set, 6'b110010);
        tick();
        chk("m_idle_busy", busy, 0);
        chk("m_idle_cen", cfg_cen, 0);
        chk_rd("m_status", A_STATUS, 32'h0028_0004);

        // Overflow: 5 pushes into a depth-4 FIFO
        for (int i = 0; i < 5; i++) begin
            wb_write(A_DATA, 32'h1111_1111 * (i + 1), 4'hF);
        end
        chk_rd("o_status1", A_STATUS, 32'h0028_040A);
        chk_rd("o_status2", A_STATUS, 32'h0028_0408);
        wb_write(A_CTRL, 32'h4000_0000, 4'hF);
        chk_rd("o_flushed", A_STATUS, 32'h0028_0004);

        // Abort mid-shift
        wb_write(A_LEN, 32'd64, 4'hF);
        wb_write(A_DATA, 32'hFFFF_FFFF, 4'hF);
        wb_write(A_DATA, 32'hFFFF_FFFF, 4'hF);
        wb_write(A_CTRL, 32'h8000_003F, 4'hF);
        tick();
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("a_shift", cfg_shift, 6'h3F);
        end
        wb_write(A_CTRL, 32'h4000_0000, 4'hF);
        chk("a_ack_busy", busy, 1);
        tick();
        chk("a_cen", cfg_cen, 0);
        chk("a_shift0", cfg_shift, 0);
        chk("a_data0", cfg_data, 0);
        chk("a_set0", cfg_set, 0);
        chk("a_busy0", busy, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("a_noset", cfg_set, 0);
        end
        wb_read(A_STATUS, st);
        chk("a_status", st & 32'h0000_FFFF, 32'h0000_0004);

        // LEN = 0 commit
        wb_write(A_LEN, 32'd0, 4'hF);
        wb_write(A_CTRL, 32'h8000_003F, 4'hF);
        tick();
        chk("z_set", cfg_set, 6'h3F);
        chk("z_shift", cfg_shift, 0);
        chk("z_busy", busy, 1);
        tick();
        chk("z_set_off", cfg_set, 0);
        chk("z_busy_off", busy, 0);
        chk_rd("z_status", A_STATUS, 32'h0000_0004);

        // Address decode, read-zero registers, partial byte select
        wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = 1'b0;
        wbs_addr_i = BASE + 32'h100; wbs_sel_i = 4'hF;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("d_noack", wbs_ack_o, 0);
            chk("d_nodata", wbs_data_o, 0);
        end
        wbs_cyc_i = 1'b0; wbs_addr_i = A_STATUS;
        tick();
        tick();
        chk("d_nocyc", wbs_ack_o, 0);
        wbs_stb_i = 1'b0;
        chk_rd("d_ctrl_rd", A_CTRL, 32'h0);
        chk_rd("d_data_rd", A_DATA, 32'h0);
        wb_write(A_LEN, 32'd8, 4'hF);
        wb_write(A_LEN, 32'h0000_1234, 4'h3);
        chk_rd("d_len_rd", A_LEN, 32'd8);

        // COMMIT while busy is ignored
        wb_write(A_DATA, 32'h0000_00A5, 4'hF);
        wb_write(A_CTRL, 32'h8000_0005, 4'hF);
        tick();
        tick();
        chk("c_data0", cfg_data, 6'b000101);
        wb_write(A_CTRL, 32'h8000_003F, 4'hF);
        w = 32'h0000_00A5;
        chk("c_shift1", cfg_shift, 6'b000101);
        chk("c_data1", cfg_data, 6'b0);
        for (int i = 2; i < 8; i++) begin
            tick();
            chk("c_shift", cfg_shift, 6'b000101);
            chk("c_data", cfg_data, w[i] ? 6'b000101 : 6'b0);
        end
        tick();
        chk("c_set", cfg_set, 6'b000101);
        tick();
        chk("c_idle", busy, 0);
        tick();
        chk("c_still_idle", busy, 0);
        chk_rd("c_status", A_STATUS, 32'h0008_0004);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
